// File: rtl/tile_render_pkg.sv
// Shared LCD command bytes, colour/state types and the default tile palette
// for the tile frame renderer.
package tile_render_pkg;

  localparam logic [7:0] CMD_SWRESET  = 8'h01;
  localparam logic [7:0] CMD_SLPOUT   = 8'h11;
  localparam logic [7:0] CMD_COLMOD   = 8'h3A;
  localparam logic [7:0] CMD_DISPON   = 8'h29;
  localparam logic [7:0] CMD_CASET    = 8'h2A;
  localparam logic [7:0] CMD_PASET    = 8'h2B;
  localparam logic [7:0] CMD_RAMWR    = 8'h2C;
  localparam logic [7:0] COLMOD_16BPP = 8'h55;

  localparam int unsigned PAL_OBJ_W = 3;
  localparam int unsigned PAL_N     = 1 << PAL_OBJ_W;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [3:0] {
    S_INIT_BYTE,
    S_INIT_WAIT,
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_HDR,
    S_PIX,
    S_NEXT,
    S_DONE
  } state_t;

  // Rows: normal palette 0, normal palette 1, game-over palette.
  localparam rgb565_t DEFAULT_PALETTE [3][PAL_N] = '{
    '{16'h0000, 16'h07E0, 16'hF800, 16'h001F, 16'hFFE0, 16'hF81F, 16'h07FF, 16'hFFFF},
    '{16'h18E3, 16'h03E0, 16'h7800, 16'h000F, 16'h7BE0, 16'h780F, 16'h03EF, 16'hC618},
    '{16'h2104, 16'hF800, 16'hFBE0, 16'hF81F, 16'hFFFF, 16'h8000, 16'h8410, 16'h0000}
  };

  function automatic rgb565_t palette_lookup(input logic [1:0] sel,
                                             input logic [PAL_OBJ_W-1:0] idx);
    case (sel)
      2'd0:    return DEFAULT_PALETTE[0][idx];
      2'd1:    return DEFAULT_PALETTE[1][idx];
      default: return DEFAULT_PALETTE[2][idx];
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// 8080-style byte strobe generator: one byte per req/ack handshake, wrx low
// for WR_LOW clocks then high for WR_HIGH clocks, dcx/data held throughout.
module lcd_byte_writer #(
  parameter int unsigned WR_LOW  = 1,
  parameter int unsigned WR_HIGH = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req,
  input  logic       dcx,
  input  logic [7:0] data,
  output logic       ack,
  output logic       idle,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic [7:0] lcd_d
);

  localparam int unsigned MAXPH = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int unsigned CW    = $clog2(MAXPH + 1);

  logic          active;
  logic          low_phase;
  logic [CW-1:0] cnt;

  // ack marks the last high-phase clock; a req seen then starts the next byte
  // on the following edge with no idle gap.
  assign ack  = active && !low_phase && (cnt == '0);
  assign idle = !active;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active    <= 1'b0;
      low_phase <= 1'b0;
      cnt       <= '0;
      lcd_wrx   <= 1'b1;
      lcd_dcx   <= 1'b1;
      lcd_d     <= '0;
    end else if (req && (idle || ack)) begin
      active    <= 1'b1;
      low_phase <= 1'b1;
      cnt       <= CW'(WR_LOW - 1);
      lcd_wrx   <= 1'b0;
      lcd_dcx   <= dcx;
      lcd_d     <= data;
    end else if (active) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else if (low_phase) begin
        low_phase <= 1'b0;
        lcd_wrx   <= 1'b1;
        cnt       <= CW'(WR_HIGH - 1);
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tile_frame_renderer.sv
// Scans the tile grid, redraws only cells whose object code changed since the
// last frame. Optional power-up LCD init sequence via `define LCD_INIT_SEQ_EN.
module tile_frame_renderer
  import tile_render_pkg::*;
#(
  parameter  int unsigned GRID_W  = 16,
  parameter  int unsigned GRID_H  = 16,
  parameter  int unsigned CELL_PX = 10,
  parameter  int unsigned X_OFF   = 0,
  parameter  int unsigned Y_OFF   = 0,
  parameter  int unsigned OBJ_W   = 3,
  parameter  int unsigned WR_LOW  = 1,
  parameter  int unsigned WR_HIGH = 1,
  localparam int unsigned CXW     = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int unsigned CYW     = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             frame_start,
  input  logic             mode,
  input  logic             game_over,
  output logic [CXW-1:0]   cell_x,
  output logic [CYW-1:0]   cell_y,
  input  logic [OBJ_W-1:0] obj_code,
  output logic             busy,
  output logic             frame_done,
  output logic             lcd_csx,
  output logic             lcd_dcx,
  output logic             lcd_wrx,
  output logic [7:0]       lcd_d
);

  localparam int unsigned NCELLS    = GRID_W * GRID_H;
  localparam int unsigned IW        = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int unsigned PIX_BYTES = 2 * CELL_PX * CELL_PX;
  localparam int unsigned PW        = $clog2(PIX_BYTES + 1);

  state_t           state;
  logic [OBJ_W-1:0] shadow [NCELLS];
  logic [OBJ_W-1:0] obj_q;
  logic [IW-1:0]    cell_idx;
  logic [3:0]       hdr_idx;
  logic [PW-1:0]    pix_cnt;
  rgb565_t          color;
  logic             force_full;
  logic             pal_mode;
  logic             go_prev, go_pend, go_latched, go_now;
  logic [15:0]      x0, x1, y0, y1;
  logic [8:0]       hdr_word;
  logic             wr_req, wr_dcx, wr_ack, wr_idle, wr_ready;
  logic [7:0]       wr_data;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0]  init_idx;
  logic [16:0] wait_cnt;
  logic [8:0]  init_word;

  always_comb begin
    case (init_idx)
      3'd0:    init_word = {1'b0, CMD_SWRESET};
      3'd1:    init_word = {1'b0, CMD_SLPOUT};
      3'd2:    init_word = {1'b0, CMD_COLMOD};
      3'd3:    init_word = {1'b1, COLMOD_16BPP};
      default: init_word = {1'b0, CMD_DISPON};
    endcase
  end
`endif

  assign cell_idx = IW'(32'(cell_y) * GRID_W + 32'(cell_x));
  assign wr_ready = wr_idle || wr_ack;
  assign go_now   = go_pend || (game_over && !go_prev);

  always_comb begin
    x0 = 16'(X_OFF + 32'(cell_x) * CELL_PX);
    x1 = 16'(32'(x0) + CELL_PX - 1);
    y0 = 16'(Y_OFF + 32'(cell_y) * CELL_PX);
    y1 = 16'(32'(y0) + CELL_PX - 1);
    case (hdr_idx)
      4'd0:    hdr_word = {1'b0, CMD_CASET};
      4'd1:    hdr_word = {1'b1, x0[15:8]};
      4'd2:    hdr_word = {1'b1, x0[7:0]};
      4'd3:    hdr_word = {1'b1, x1[15:8]};
      4'd4:    hdr_word = {1'b1, x1[7:0]};
      4'd5:    hdr_word = {1'b0, CMD_PASET};
      4'd6:    hdr_word = {1'b1, y0[15:8]};
      4'd7:    hdr_word = {1'b1, y0[7:0]};
      4'd8:    hdr_word = {1'b1, y1[15:8]};
      4'd9:    hdr_word = {1'b1, y1[7:0]};
      default: hdr_word = {1'b0, CMD_RAMWR};
    endcase
  end

  always_comb begin
    wr_req  = 1'b0;
    wr_dcx  = 1'b1;
    wr_data = '0;
    case (state)
      S_HDR: begin
        wr_req            = 1'b1;
        {wr_dcx, wr_data} = hdr_word;
      end
      S_PIX: begin
        wr_req  = 1'b1;
        wr_data = pix_cnt[0] ? color[7:0] : color[15:8];
      end
`ifdef LCD_INIT_SEQ_EN
      S_INIT_BYTE: begin
        wr_req            = 1'b1;
        {wr_dcx, wr_data} = init_word;
      end
`endif
      default: ;
    endcase
  end

  lcd_byte_writer #(
    .WR_LOW (WR_LOW),
    .WR_HIGH(WR_HIGH)
  ) u_writer (
    .clk    (clk),
    .nrst   (nrst),
    .req    (wr_req),
    .dcx    (wr_dcx),
    .data   (wr_data),
    .ack    (wr_ack),
    .idle   (wr_idle),
    .lcd_dcx(lcd_dcx),
    .lcd_wrx(lcd_wrx),
    .lcd_d  (lcd_d)
  );

  // No reset: after reset force_full makes the first frame ignore the shadow.
  always_ff @(posedge clk) begin
    if (state == S_PIX && wr_ready && pix_cnt == PW'(PIX_BYTES - 1))
      shadow[cell_idx] <= obj_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
`ifdef LCD_INIT_SEQ_EN
      state    <= S_INIT_BYTE;
      init_idx <= '0;
      wait_cnt <= '0;
`else
      state    <= S_IDLE;
`endif
      busy       <= 1'b0;
      frame_done <= 1'b0;
      lcd_csx    <= 1'b1;
      cell_x     <= '0;
      cell_y     <= '0;
      force_full <= 1'b1;
      hdr_idx    <= '0;
      pix_cnt    <= '0;
      color      <= '0;
      obj_q      <= '0;
      pal_mode   <= 1'b0;
      go_prev    <= 1'b0;
      go_pend    <= 1'b0;
      go_latched <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      go_prev    <= game_over;
      if (game_over && !go_prev) go_pend <= 1'b1;
      case (state)
`ifdef LCD_INIT_SEQ_EN
        S_INIT_BYTE: begin
          busy    <= 1'b1;
          lcd_csx <= 1'b0;
          if (wr_ready) begin
            init_idx <= init_idx + 3'd1;
            if (init_idx <= 3'd1 || init_idx == 3'd4) begin
              wait_cnt <= '0;
              state    <= S_INIT_WAIT;
            end
          end
        end
        S_INIT_WAIT: begin
          if (wr_idle) begin
            if (init_idx == 3'd5) begin
              busy    <= 1'b0;
              lcd_csx <= 1'b1;
              state   <= S_IDLE;
            end else if (wait_cnt == '1) begin
              state <= S_INIT_BYTE;
            end else begin
              wait_cnt <= wait_cnt + 17'd1;
            end
          end
        end
`endif
        S_IDLE: begin
          if (frame_start && !frame_done) begin
            busy     <= 1'b1;
            lcd_csx  <= 1'b0;
            cell_x   <= '0;
            cell_y   <= '0;
            pal_mode <= mode;
            state    <= S_FETCH;
            if (go_now) begin
              go_latched <= 1'b1;
              go_pend    <= 1'b0;
            end
            if (go_now || mode != pal_mode) force_full <= 1'b1;
          end
        end
        S_FETCH: state <= S_CMP;
        S_CMP: begin
          obj_q <= obj_code;
          color <= palette_lookup(go_latched ? 2'd2 : {1'b0, pal_mode},
                                  PAL_OBJ_W'(obj_code));
          if (obj_code == shadow[cell_idx] && !force_full) begin
            state <= S_NEXT;
          end else begin
            hdr_idx <= '0;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (wr_ready) begin
            if (hdr_idx == 4'd10) begin
              pix_cnt <= '0;
              state   <= S_PIX;
            end else begin
              hdr_idx <= hdr_idx + 4'd1;
            end
          end
        end
        S_PIX: begin
          if (wr_ready) begin
            if (pix_cnt == PW'(PIX_BYTES - 1)) state <= S_NEXT;
            else pix_cnt <= pix_cnt + PW'(1);
          end
        end
        S_NEXT: begin
          if (cell_x == CXW'(GRID_W - 1)) begin
            cell_x <= '0;
            if (cell_y == CYW'(GRID_H - 1)) begin
              state <= S_DONE;
            end else begin
              cell_y <= cell_y + CYW'(1);
              state  <= S_FETCH;
            end
          end else begin
            cell_x <= cell_x + CXW'(1);
            state  <= S_FETCH;
          end
        end
        S_DONE: begin
          // Hold csx low until the final byte has fully left the bus.
          if (wr_idle) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            lcd_csx    <= 1'b1;
            force_full <= 1'b0;
            cell_x     <= '0;
            cell_y     <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
